// File: rtl/vlc_bit_packer_if.sv
//------------------------------------------------------------------------------
// Module  : vlc_bit_packer_if
// Brief   : Symbol input, VLC table port and packed-word output of the packer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vlc_bit_packer_if #(
  parameter int SYM_W = 8,
  parameter int SEG_W = 4,
  parameter int OUT_W = 32
);
  localparam int BYTES_W = $clog2(OUT_W / 8) + 1;

  logic                   in_valid;
  logic [SYM_W-1:0]       in_data;
  logic                   in_last;
  logic                   in_ready;

  logic [SYM_W+SEG_W-1:0] vlc_addr;
  logic [21:0]            vlc_dout;

  logic                   out_valid;
  logic [OUT_W-1:0]       out_data;
  logic                   out_last;
  logic [BYTES_W-1:0]     out_bytes;
  logic                   out_ready;

  // master: the packer itself; slave: symbol source, table RAM and stream writer
  modport master (
    input  in_valid, in_data, in_last, vlc_dout, out_ready,
    output in_ready, vlc_addr, out_valid, out_data, out_last, out_bytes
  );

  modport slave (
    output in_valid, in_data, in_last, vlc_dout, out_ready,
    input  in_ready, vlc_addr, out_valid, out_data, out_last, out_bytes
  );
endinterface

`default_nettype wire

// File: rtl/vlc_bit_packer.sv
//------------------------------------------------------------------------------
// Module  : vlc_bit_packer
// Brief   : Walks VLC table segments per symbol and packs code bits MSB-first
//           into OUT_W-bit words. Optional VLC_PACK_BITCNT_EN adds total_bits.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vlc_bit_packer #(
  parameter int SYM_W = 8,
  parameter int SEG_W = 4,
  parameter int OUT_W = 32
) (
  input  wire logic        clk,
  input  wire logic        rstN,
  input  wire logic        enc_start,
  output logic             enc_done,
  output logic             err_len,
  vlc_bit_packer_if.master bus
`ifdef VLC_PACK_BITCNT_EN
  ,
  output logic [31:0]      total_bits
`endif
);

  localparam int ACC_W   = OUT_W + 16;
  localparam int CNT_W   = $clog2(ACC_W);
  localparam int BYTES_W = $clog2(OUT_W / 8) + 1;

  localparam logic [CNT_W-1:0]   c_OUT_W_CNT  = CNT_W'(OUT_W);
  localparam logic [BYTES_W-1:0] c_FULL_BYTES = BYTES_W'(OUT_W / 8);
  localparam logic [SEG_W-1:0]   c_SEG_MAX    = {SEG_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_RD     = 3'd2,
    S_APPEND = 3'd3,
    S_FLUSH  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;

  logic             w_ext;
  logic [4:0]       w_len;
  logic [15:0]      w_code;
  logic [15:0]      w_code_al;
  logic             w_len_ok;
  logic             w_active;
  logic             w_full;
  logic             w_emit;
  logic             w_final;
  logic             w_append;
  logic             w_seg_end;
  logic [SEG_W-1:0] w_seg;
  logic [BYTES_W-1:0] w_tail_bytes;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_next;
  logic [ACC_W-1:0] w_acc_base;
  logic [ACC_W-1:0] w_acc_next;
  logic [ACC_W-1:0] w_ins;

  assign w_ext    = bus.vlc_dout[21];
  assign w_len    = bus.vlc_dout[20:16];
  assign w_code   = bus.vlc_dout[15:0];
  assign w_len_ok = (w_len != 5'd0) && (w_len <= 5'd16);
  assign w_seg    = bus.vlc_addr[SEG_W-1:0];

  // Shifting left by (16-len) drops any stray bits above the segment length
  assign w_code_al = w_code << (5'd16 - w_len);

  assign w_active  = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_full    = (r_cnt >= c_OUT_W_CNT);
  assign w_emit    = w_active && w_full && !bus.out_valid;
  assign w_final   = (r_state == S_FLUSH) && !w_full && !bus.out_valid;
  assign w_append  = (r_state == S_APPEND) && !w_full && w_len_ok;
  assign w_seg_end = (r_state == S_APPEND) && !w_full &&
                     (!w_len_ok || !w_ext || (w_seg == c_SEG_MAX));

  assign w_tail_bytes = BYTES_W'((r_cnt + CNT_W'(7)) >> 3);

  assign bus.in_ready = (r_state == S_ACCEPT) && !w_full;

  always_comb begin
    w_cnt_base = r_cnt;
    w_acc_base = r_acc;
    if (w_emit) begin
      w_cnt_base = r_cnt - c_OUT_W_CNT;
      w_acc_base = r_acc << OUT_W;
    end
    w_ins      = {w_code_al, {OUT_W{1'b0}}} >> w_cnt_base;
    w_acc_next = w_acc_base;
    w_cnt_next = w_cnt_base;
    if (w_append) begin
      w_acc_next = w_acc_base | w_ins;
      w_cnt_next = w_cnt_base + CNT_W'(w_len);
    end
    if (w_final) begin
      w_acc_next = '0;
      w_cnt_next = '0;
    end
  end

`ifdef VLC_PACK_BITCNT_EN
  logic [32:0] w_bits_sum;
  assign w_bits_sum = {1'b0, total_bits} + 33'(w_len);
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_last        <= 1'b0;
      enc_done      <= 1'b0;
      err_len       <= 1'b0;
      bus.vlc_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_bytes <= '0;
`ifdef VLC_PACK_BITCNT_EN
      total_bits    <= '0;
`endif
    end else if (enc_start) begin
      // Restart wins over everything, including a same-cycle symbol handshake
      r_state       <= S_ACCEPT;
      r_acc         <= '0;
      r_cnt         <= '0;
      enc_done      <= 1'b0;
      err_len       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
`ifdef VLC_PACK_BITCNT_EN
      total_bits    <= '0;
`endif
    end else begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;

      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
      if (w_emit || w_final) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= r_acc[ACC_W-1 -: OUT_W];
        bus.out_bytes <= w_emit ? c_FULL_BYTES : w_tail_bytes;
        bus.out_last  <= w_final;
      end

`ifdef VLC_PACK_BITCNT_EN
      if (w_append)
        total_bits <= w_bits_sum[32] ? 32'hFFFF_FFFF : w_bits_sum[31:0];
`endif

      case (r_state)
        S_ACCEPT: begin
          if (bus.in_valid && bus.in_ready) begin
            r_last       <= bus.in_last;
            bus.vlc_addr <= {bus.in_data, {SEG_W{1'b0}}};
            r_state      <= S_RD;
          end
        end
        S_RD: r_state <= S_APPEND;
        S_APPEND: begin
          if (!w_full) begin
            if (!w_len_ok)
              err_len <= 1'b1;
            else if (w_ext && (w_seg != c_SEG_MAX)) begin
              bus.vlc_addr <= {bus.vlc_addr[SYM_W+SEG_W-1:SEG_W], w_seg + SEG_W'(1)};
              r_state      <= S_RD;
            end else if (w_ext)
              err_len <= 1'b1;
            if (w_seg_end)
              r_state <= r_last ? S_FLUSH : S_ACCEPT;
          end
        end
        S_FLUSH: begin
          if (bus.out_valid && bus.out_ready && bus.out_last) begin
            r_state  <= S_DONE;
            enc_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
